apb_irq_ctrl: RTL and testbench
===============================

// Module: apb_irq_ctrl
// PURPOSE
//   APB-slave interrupt controller directly downstream of the APB timer and peer
//   APB peripherals. Captures rising edges on NSRC interrupt lines (timer irq is a
//   1-cycle pulse) into pending bits, masks them with an enable register and drives
//   one CPU interrupt line. Software services it via claim-read and W1C.
// PARAMETERS
//   NSRC      8   number of interrupt sources, 1..31; source 0 has highest priority
// PORTS
//   pclk      in   1     APB clock; the only clock
//   preset    in   1     synchronous active-high reset
//   psel      in   1     APB select
//   penable   in   1     APB enable (access phase)
//   pwrite    in   1     1=write, 0=read
//   paddr     in   32    byte address; only paddr[3:2] decoded
//   pwdata    in   32    write data
//   prdata    out  32    read data, registered
//   pready    out  1     transfer-complete strobe, registered
//   irq_src   in   NSRC  interrupt inputs (pulse or level); bit i = source i
//   irq_out   out  1     CPU interrupt, registered, active-high level
// BEHAVIOUR
//   Reset (preset=1 at a pclk edge): prdata=0, pready=0, irq_out=0, pending=0,
//     enable=0, src_q=0, FSM=IDLE. Reset mid-transfer abandons the transfer.
//   Registers (paddr[3:2]):
//     00 PENDING  R: {0, pending}  W: write-1-to-clear
//     01 ENABLE   R/W: {0, enable}; bits >= NSRC read 0, writes ignored
//     10 CLAIM    R: {1'b1, 26'b0, id[4:0]} of lowest-index set bit of
//                    pending&enable, and clears that pending bit; 0 if none. W: ignored
//     11 RAW      R: {0, irq_src} sampled this cycle. W: ignored
//   APB FSM, two states:
//     IDLE:   psel&penable -> perform access, pready<=1, prdata<=read value
//             (writes: prdata<=0), go ACK. Else pready<=0.
//     ACK:    pready<=0, no access performed, go IDLE (one extra cycle, so
//             back-to-back transfers never double-execute).
//     pready high exactly 1 cycle per transfer, the cycle after the first
//     psel&penable cycle; prdata valid in that same cycle.
//   Edge capture: src_q<=irq_src every cycle; rise[i]=irq_src[i]&~src_q[i].
//     rise at edge k -> pending[i]=1 after edge k -> irq_out=1 after edge k+1.
//     A held-high level sets pending once; must drop and rise again to re-set.
//   irq_out <= |(pending & enable), recomputed every cycle (1-cycle latency).
//     Clearing enable or pending drops irq_out on the following edge.
//   Simultaneous events, same edge, same bit: rise wins over W1C or claim
//     clear (bit stays 1). Bits not being cleared are unaffected.
//   CLAIM picks and clears against pending as of the access cycle; a rise on the
//     claimed bit in that cycle leaves it set.
//   Masked sources still latch pending; setting enable later raises irq_out.
// TESTING
//   1 reset: preset=1 two cycles, irq_src=8'hFF held -> prdata=0, pready=0,
//     irq_out=0, PENDING read later = 0 (held level seen at reset release
//     counts as a rise only if src_q was 0).
//   2 timer pulse: ENABLE=1, 1-cycle pulse on irq_src[0] -> pending[0]=1
//     next edge, irq_out=1 one edge later; CLAIM read -> 32'h8000_0000,
//     irq_out=0 two edges after the pready cycle.
//   3 priority: ENABLE=8'h0C, pulse src 2,3 together -> CLAIM=32'h8000_0002,
//     then 32'h8000_0003, then 32'h0000_0000.
//   4 masking/W1C: ENABLE=0, pulse src 5 -> irq_out stays 0, PENDING=32'h20;
//     write ENABLE=32'h20 -> irq_out=1; write PENDING=32'h20 -> irq_out=0.
//   5 collision: W1C of bit 1 in the same cycle as a rise on src 1 ->
//     PENDING reads 32'h2.
//   6 APB timing: back-to-back reads with penable held two cycles ->
//     one pready per transfer; a CLAIM clears exactly one bit.

Source files
------------

// File: rtl/apb_irq_ctrl.sv
// APB interrupt controller: rising-edge capture into pending bits, enable mask,
// claim-read of the lowest-index enabled pending source, and W1C clear.

module apb_irq_cell (
  input  logic pclk,
  input  logic preset,
  input  logic src,
  input  logic clr,
  output logic pend
);
  logic src_q;

  // A rise on the same edge as a clear wins, so a fresh event is never lost.
  always_ff @(posedge pclk) begin
    if (preset) begin
      src_q <= 1'b0;
      pend  <= 1'b0;
    end else begin
      src_q <= src;
      pend  <= (src & ~src_q) | (pend & ~clr);
    end
  end
endmodule

module apb_irq_ctrl #(
  parameter int NSRC = 8
) (
  input  logic            pclk,
  input  logic            preset,
  input  logic            psel,
  input  logic            penable,
  input  logic            pwrite,
  input  logic [31:0]     paddr,
  input  logic [31:0]     pwdata,
  output logic [31:0]     prdata,
  output logic            pready,
  input  logic [NSRC-1:0] irq_src,
  output logic            irq_out
);
  typedef enum logic {IDLE, ACK} state_t;

  state_t          state, state_n;
  logic            access;
  logic [NSRC-1:0] pending, enable, masked, clr, claim_oh;
  logic            claim_hit;
  logic [4:0]      claim_id;
  logic [31:0]     rdata;
  logic            unused;

  assign unused = ^{paddr[31:4], paddr[1:0], pwdata[31:NSRC]};
  assign masked = pending & enable;

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
    apb_irq_cell u_cell (
      .pclk   (pclk),
      .preset (preset),
      .src    (irq_src[gi]),
      .clr    (clr[gi]),
      .pend   (pending[gi])
    );
  end

  always_ff @(posedge pclk) begin
    if (preset) state <= IDLE;
    else        state <= state_n;
  end

  // ACK is a dead cycle so a held penable cannot execute a second access.
  always_comb begin
    state_n = state;
    access  = 1'b0;
    case (state)
      IDLE: if (psel && penable) begin
        access  = 1'b1;
        state_n = ACK;
      end
      ACK:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Scan from the top down so the lowest index is the last (winning) assignment.
  always_comb begin
    claim_hit = 1'b0;
    claim_id  = '0;
    claim_oh  = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (masked[i]) begin
        claim_hit   = 1'b1;
        claim_id    = 5'(i);
        claim_oh    = '0;
        claim_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (paddr[3:2])
      2'd0:    rdata[NSRC-1:0] = pending;
      2'd1:    rdata[NSRC-1:0] = enable;
      2'd2:    if (claim_hit) rdata = {1'b1, 26'b0, claim_id};
      default: rdata[NSRC-1:0] = irq_src;
    endcase
  end

  always_comb begin
    clr = '0;
    if (access) begin
      if (pwrite && paddr[3:2] == 2'd0)       clr = pwdata[NSRC-1:0];
      else if (!pwrite && paddr[3:2] == 2'd2) clr = claim_oh;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      prdata  <= '0;
      pready  <= 1'b0;
      irq_out <= 1'b0;
      enable  <= '0;
    end else begin
      pready  <= access;
      irq_out <= |masked;
      if (access) prdata <= pwrite ? 32'd0 : rdata;
      if (access && pwrite && paddr[3:2] == 2'd1) enable <= pwdata[NSRC-1:0];
    end
  end
endmodule

// File: tb/tb_apb_irq_ctrl.sv
// Scoreboard bench for apb_irq_ctrl: a per-edge behavioural model queues the
// expected read data; a negedge monitor compares pready, prdata and irq_out.

module tb_apb_irq_ctrl;
  localparam int NSRC = 8;

  logic            pclk = 1'b0;
  logic            preset, psel, penable, pwrite;
  logic [31:0]     paddr, pwdata, prdata;
  logic            pready, irq_out;
  logic [NSRC-1:0] irq_src;

  int total = 0;
  int bad   = 0;

  apb_irq_ctrl #(.NSRC(NSRC)) dut (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .irq_src(irq_src), .irq_out(irq_out)
  );

  always #5 pclk = ~pclk;

  // reference model state
  logic [NSRC-1:0] m_pend, m_en, m_srcq;
  logic            m_accp, exp_pready, irq_exp, exp_rst, started;
  logic [31:0]     exp_q[$];
  logic [31:0]     last_rd;
  int              rdy_cnt = 0;

  initial begin
    started = 1'b0;
    forever begin
      logic [NSRC-1:0] clr, rise;
      logic [31:0]     rd;
      logic            acc;
      @(posedge pclk);
      started = 1'b1;
      if (preset) begin
        m_pend = '0; m_en = '0; m_srcq = '0; m_accp = 1'b0;
        exp_pready = 1'b0; irq_exp = 1'b0; exp_rst = 1'b1;
        exp_q.delete();
      end else begin
        exp_rst = 1'b0;
        acc  = psel && penable && !m_accp;
        rise = irq_src & ~m_srcq;
        clr  = '0;
        rd   = '0;
        if (acc) begin
          case (paddr[3:2])
            2'd0: if (pwrite) clr = pwdata[NSRC-1:0]; else rd = 32'(m_pend);
            2'd1: if (!pwrite) rd = 32'(m_en);
            2'd2: if (!pwrite) begin
              for (int i = 0; i < NSRC; i++) begin
                if (m_pend[i] && m_en[i]) begin
                  rd     = 32'h8000_0000 | 32'(i);
                  clr[i] = 1'b1;
                  break;
                end
              end
            end
            default: if (!pwrite) rd = 32'(irq_src);
          endcase
          exp_q.push_back(rd);
        end
        irq_exp    = |(m_pend & m_en);
        exp_pready = acc;
        if (acc && pwrite && paddr[3:2] == 2'd1) m_en = pwdata[NSRC-1:0];
        m_pend = (m_pend & ~clr) | rise;
        m_srcq = irq_src;
        m_accp = acc;
      end
    end
  end

  initial begin
    forever begin
      @(negedge pclk);
      if (started) begin
        total++;
        if (pready !== exp_pready) begin
          bad++; $display("FAIL pready: got %b want %b @%0t", pready, exp_pready, $time);
        end
        total++;
        if (irq_out !== irq_exp) begin
          bad++; $display("FAIL irq_out: got %b want %b @%0t", irq_out, irq_exp, $time);
        end
        if (exp_rst) begin
          total++;
          if (prdata !== 32'd0) begin
            bad++; $display("FAIL reset prdata: got %h want 0", prdata);
          end
        end
        if (pready) begin
          rdy_cnt++;
          last_rd = prdata;
          total++;
          if (exp_q.size() == 0) begin
            bad++; $display("FAIL prdata: unexpected pready, got %h want none", prdata);
          end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (prdata !== e) begin
              bad++; $display("FAIL prdata: got %h want %h @%0t", prdata, e, $time);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++; $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge pclk); #1; end
  endtask

  task automatic xfer(input bit wr, input logic [1:0] a, input logic [31:0] d,
                      input int hold, input bit pulse_en, input logic [NSRC-1:0] pulse);
    psel = 1'b1; penable = 1'b0; pwrite = wr; pwdata = d;
    paddr = {28'($urandom), a, 2'($urandom)};
    @(posedge pclk); #1;
    penable = 1'b1;
    if (pulse_en) irq_src = pulse;
    @(posedge pclk); #1;
    if (pulse_en) irq_src = '0;
    if (hold == 2) begin @(posedge pclk); #1; end
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
  endtask

  task automatic rd(input logic [1:0] a);
    xfer(1'b0, a, $urandom, 1, 1'b0, '0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    xfer(1'b1, a, d, 1, 1'b0, '0);
  endtask

  task automatic pulse(input logic [NSRC-1:0] v);
    irq_src = v; @(posedge pclk); #1;
    irq_src = '0; @(posedge pclk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    bit done;
    int c0;
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; irq_src = 8'hFF;
    idle(2);
    irq_src = '0;
    idle(1);
    preset = 1'b0;
    idle(1);
    chk("rst pready", {31'd0, pready}, 32'd0);
    chk("rst irq_out", {31'd0, irq_out}, 32'd0);
    rd(2'd0);  chk("rst pending", last_rd, 32'd0);

    // timer pulse on source 0
    wr(2'd1, 32'h1);
    pulse(8'h01);
    chk("pulse irq_out", {31'd0, irq_out}, 32'd1);
    rd(2'd2);  chk("claim src0", last_rd, 32'h8000_0000);
    idle(1);
    chk("claim irq drop", {31'd0, irq_out}, 32'd0);

    // priority
    wr(2'd1, 32'h0C);
    pulse(8'h0C);
    rd(2'd2);  chk("claim prio 2", last_rd, 32'h8000_0002);
    rd(2'd2);  chk("claim prio 3", last_rd, 32'h8000_0003);
    rd(2'd2);  chk("claim none", last_rd, 32'h0000_0000);

    // masking and W1C
    wr(2'd1, 32'h0);
    pulse(8'h20);
    idle(2);
    chk("masked irq", {31'd0, irq_out}, 32'd0);
    rd(2'd0);  chk("masked pending", last_rd, 32'h20);
    wr(2'd1, 32'h20);
    idle(1);
    chk("unmask irq", {31'd0, irq_out}, 32'd1);
    wr(2'd0, 32'h20);
    idle(1);
    chk("w1c irq", {31'd0, irq_out}, 32'd0);
    rd(2'd1);  chk("enable rb", last_rd, 32'h20);

    // collision: W1C bit 1 on the same edge as a rise on source 1
    pulse(8'h02);
    xfer(1'b1, 2'd0, 32'h2, 1, 1'b1, 8'h02);
    rd(2'd0);  chk("w1c collision", last_rd, 32'h2);
    wr(2'd1, 32'h2);
    xfer(1'b0, 2'd2, 32'h0, 1, 1'b1, 8'h02);
    chk("claim collision rd", last_rd, 32'h8000_0001);
    rd(2'd0);  chk("claim collision pend", last_rd, 32'h2);
    wr(2'd0, 32'hFF);

    // penable held two cycles
    wr(2'd1, 32'h3);
    pulse(8'h03);
    c0 = rdy_cnt;
    xfer(1'b0, 2'd2, 32'h0, 2, 1'b0, '0);
    chk("hold one pready", 32'(rdy_cnt - c0), 32'd1);
    chk("hold claim", last_rd, 32'h8000_0000);
    xfer(1'b0, 2'd0, 32'h0, 2, 1'b0, '0);
    chk("hold one clear", last_rd, 32'h2);
    rd(2'd3);  chk("raw idle", last_rd, 32'h0);

    // randomized traffic, source activity decoupled from the bus
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          logic [31:0] d;
          d = $urandom;
          if ($urandom_range(3) == 0) d = d & 32'hFF;
          xfer(1'($urandom), 2'($urandom), d, int'($urandom_range(1, 2)), 1'b0, '0);
          if ($urandom_range(3) == 0) idle(1);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          irq_src = NSRC'($urandom & $urandom);
          @(posedge pclk); #1;
        end
      end
    join
    irq_src = '0;
    idle(4);
    chk("queue drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
